midi_voice_manager: RTL and testbench

Parametrised successor to the 4-voice MIDI message handler. It decodes 3-byte MIDI messages into note and controller writes for a bank of NUM_VOICES synth voices. It allocates voices with retrigger, free-voice search and round-robin stealing. It also runs the update handshake with the mixer, supplying a per-voice gain multiplier. It sits between the MIDI UART byte assembler and the voice register file and mixer.

---
 rtl/midi_voice_manager.sv | 267 ++++++++++++++++++++++++++
 tb/tb_midi_voice_manager.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_manager.sv
// MIDI voice manager: decodes 3-byte channel messages into voice/controller
// register writes, allocates voices (retrigger, free search, round-robin
// steal) and runs the gain/update handshake with the mixer.
// Handshake note: new_msg is a one-cycle strobe taken only while busy is low;
// update_mixer arms the mixer FSM; ready_to_update completes it, producing a
// one-cycle update_all; write_en is a one-cycle strobe with no back-pressure.
module midi_voice_manager #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 5,
  parameter int CTRL_ADDR  = 16,
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_msg,
  input  logic [23:0]           msg,
  input  logic [NUM_VOICES-1:0] voices_playing,
  input  logic                  update_mixer,
  input  logic                  ready_to_update,
  output logic                  busy,
  output logic [13:0]           controller_values,
  output logic [7:0]            multiplier,
  output logic                  update_all,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [13:0]           write_values,
  output logic                  write_en,
  output logic [NUM_VOICES-1:0] update_note
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {M_IDLE, M_DECODE, M_SEARCH, M_WRITE} msg_state_e;
  typedef enum logic {X_IDLE, X_WAIT} mix_state_e;

  msg_state_e            msg_state_q, msg_state_d;
  mix_state_e            mix_state_q, mix_state_d;
  logic [23:0]           msg_q, msg_d;
  logic [IDX_W-1:0]      scan_q, scan_d;
  logic                  hit_q, hit_d, free_q, free_d;
  logic [IDX_W-1:0]      hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
  logic [NUM_VOICES-1:0] alloc_q, alloc_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [IDX_W-1:0]      steal_q, steal_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_W-1:0]     write_addr_q, write_addr_d;
  logic [13:0]           write_values_q, write_values_d;
  logic [13:0]           ctrl_q, ctrl_d;
  logic                  wr_voice_q, wr_voice_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [NUM_VOICES-1:0] update_note_q, update_note_d;
  logic                  update_all_q, update_all_d;
  logic [7:0]            multiplier_q, multiplier_d;
  logic [IDX_W-1:0]      sel;
  logic [4:0]            play_cnt;
  logic [7:0]            gain;

  logic       chan_ok;
  logic [6:0] d1, d2;
  logic [3:0] hi;
  logic       is_cc, is_on, is_off;

  assign chan_ok = (OMNI != 0) || (msg[3:0] == 4'(CHANNEL));
  assign hi      = msg_q[7:4];
  assign d1      = msg_q[14:8];
  assign d2      = msg_q[22:16];
  assign is_cc   = (hi == 4'hB);
  assign is_on   = (hi == 4'h9) && (d2 != 7'd0);
  assign is_off  = (hi == 4'h8) || ((hi == 4'h9) && (d2 == 7'd0));

  // Message FSM: decode, full voice scan, then a single register write.
  always_comb begin
    msg_state_d    = msg_state_q;
    msg_d          = msg_q;
    scan_d         = scan_q;
    hit_d          = hit_q;
    hit_idx_d      = hit_idx_q;
    free_d         = free_q;
    free_idx_d     = free_idx_q;
    alloc_d        = alloc_q;
    note_d         = note_q;
    steal_d        = steal_q;
    write_en_d     = 1'b0;
    write_addr_d   = write_addr_q;
    write_values_d = write_values_q;
    ctrl_d         = ctrl_q;
    wr_voice_d     = 1'b0;
    wr_idx_d       = wr_idx_q;
    sel            = '0;
    unique case (msg_state_q)
      M_IDLE: begin
        if (new_msg && chan_ok) begin
          msg_d       = msg;
          msg_state_d = M_DECODE;
        end
      end
      M_DECODE: begin
        scan_d = '0;
        hit_d  = 1'b0;
        free_d = 1'b0;
        if (is_cc) begin
          write_en_d     = 1'b1;
          write_addr_d   = ADDR_W'(CTRL_ADDR);
          write_values_d = {d1, d2};
          ctrl_d         = {d1, d2};
          msg_state_d    = M_WRITE;
        end else if (is_on || is_off) begin
          msg_state_d = M_SEARCH;
        end else begin
          msg_state_d = M_IDLE;
        end
      end
      M_SEARCH: begin
        // First allocated voice holding this note; first idle unallocated voice.
        if (alloc_q[scan_q] && (note_q[scan_q] == d1) && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = scan_q;
        end
        if (!alloc_q[scan_q] && !voices_playing[scan_q] && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = scan_q;
        end
        if (scan_q != LAST_IDX) begin
          scan_d = scan_q + 1'b1;
        end else if (is_on) begin
          if (hit_d) begin
            sel = hit_idx_d;
          end else if (free_d) begin
            sel = free_idx_d;
          end else begin
            sel     = steal_q;
            steal_d = (steal_q == LAST_IDX) ? '0 : steal_q + 1'b1;
          end
          alloc_d[sel]   = 1'b1;
          note_d[sel]    = d1;
          write_en_d     = 1'b1;
          write_addr_d   = ADDR_W'(sel);
          write_values_d = {d2, d1};
          wr_voice_d     = 1'b1;
          wr_idx_d       = sel;
          msg_state_d    = M_WRITE;
        end else if (hit_d) begin
          sel            = hit_idx_d;
          alloc_d[sel]   = 1'b0;
          write_en_d     = 1'b1;
          write_addr_d   = ADDR_W'(sel);
          write_values_d = {7'd0, d1};
          wr_voice_d     = 1'b1;
          wr_idx_d       = sel;
          msg_state_d    = M_WRITE;
        end else begin
          msg_state_d = M_IDLE;
        end
      end
      M_WRITE: msg_state_d = M_IDLE;
      default: msg_state_d = M_IDLE;
    endcase
  end

  // Gain = 256 / number of sounding voices, saturated to 255 for 0 or 1.
  always_comb begin
    play_cnt = '0;
    for (int i = 0; i < NUM_VOICES; i++) play_cnt = play_cnt + 5'(voices_playing[i]);
    case (play_cnt)
      5'd2:    gain = 8'd128;
      5'd3:    gain = 8'd85;
      5'd4:    gain = 8'd64;
      5'd5:    gain = 8'd51;
      5'd6:    gain = 8'd42;
      5'd7:    gain = 8'd36;
      5'd8:    gain = 8'd32;
      5'd9:    gain = 8'd28;
      5'd10:   gain = 8'd25;
      5'd11:   gain = 8'd23;
      5'd12:   gain = 8'd21;
      5'd13:   gain = 8'd19;
      5'd14:   gain = 8'd18;
      5'd15:   gain = 8'd17;
      5'd16:   gain = 8'd16;
      default: gain = 8'd255;
    endcase
  end

  // Mixer FSM: arm on update_mixer, fire update_all on ready_to_update.
  always_comb begin
    mix_state_d  = mix_state_q;
    update_all_d = 1'b0;
    multiplier_d = multiplier_q;
    unique case (mix_state_q)
      X_IDLE: if (update_mixer) mix_state_d = X_WAIT;
      X_WAIT: begin
        if (ready_to_update) begin
          mix_state_d  = X_IDLE;
          update_all_d = 1'b1;
          multiplier_d = gain;
        end
      end
      default: mix_state_d = X_IDLE;
    endcase
  end

  // Dirty mask: cleared at the end of the update_all cycle; a voice write
  // landing in that same cycle is set afterwards so it is not lost.
  always_comb begin
    update_note_d = update_all_q ? '0 : update_note_q;
    if (wr_voice_q) update_note_d[wr_idx_q] = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_state_q    <= M_IDLE;
      mix_state_q    <= X_IDLE;
      msg_q          <= '0;
      scan_q         <= '0;
      hit_q          <= 1'b0;
      hit_idx_q      <= '0;
      free_q         <= 1'b0;
      free_idx_q     <= '0;
      alloc_q        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
      steal_q        <= '0;
      write_en_q     <= 1'b0;
      write_addr_q   <= '0;
      write_values_q <= '0;
      ctrl_q         <= '0;
      wr_voice_q     <= 1'b0;
      wr_idx_q       <= '0;
      update_note_q  <= '0;
      update_all_q   <= 1'b0;
      multiplier_q   <= '0;
    end else begin
      msg_state_q    <= msg_state_d;
      mix_state_q    <= mix_state_d;
      msg_q          <= msg_d;
      scan_q         <= scan_d;
      hit_q          <= hit_d;
      hit_idx_q      <= hit_idx_d;
      free_q         <= free_d;
      free_idx_q     <= free_idx_d;
      alloc_q        <= alloc_d;
      note_q         <= note_d;
      steal_q        <= steal_d;
      write_en_q     <= write_en_d;
      write_addr_q   <= write_addr_d;
      write_values_q <= write_values_d;
      ctrl_q         <= ctrl_d;
      wr_voice_q     <= wr_voice_d;
      wr_idx_q       <= wr_idx_d;
      update_note_q  <= update_note_d;
      update_all_q   <= update_all_d;
      multiplier_q   <= multiplier_d;
    end
  end

  assign busy              = (msg_state_q != M_IDLE);
  assign controller_values = ctrl_q;
  assign multiplier        = multiplier_q;
  assign update_all        = update_all_q;
  assign write_addr        = write_addr_q;
  assign write_values      = write_values_q;
  assign write_en          = write_en_q;
  assign update_note       = update_note_q;

endmodule

// File: tb/tb_midi_voice_manager.sv
// Bench for midi_voice_manager: directed scenarios followed by random
// messages, compared against a behavioural voice-allocation model.
module tb_midi_voice_manager;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_msg = 1'b0;
  logic [23:0] msg = '0;
  logic [3:0]  voices_playing = '0;
  logic        update_mixer = 1'b0;
  logic        ready_to_update = 1'b0;

  logic        busy, update_all, write_en;
  logic [13:0] controller_values, write_values;
  logic [7:0]  multiplier;
  logic [4:0]  write_addr;
  logic [3:0]  update_note;

  logic        o_busy, o_update_all, o_write_en;
  logic [13:0] o_controller_values, o_write_values;
  logic [7:0]  o_multiplier;
  logic [4:0]  o_write_addr;
  logic [3:0]  o_update_note;

  midi_voice_manager #(.NUM_VOICES(NV), .ADDR_W(5), .CTRL_ADDR(16), .CHANNEL(0), .OMNI(0)) dut (
    .clk(clk), .reset(reset), .new_msg(new_msg), .msg(msg),
    .voices_playing(voices_playing), .update_mixer(update_mixer),
    .ready_to_update(ready_to_update), .busy(busy),
    .controller_values(controller_values), .multiplier(multiplier),
    .update_all(update_all), .write_addr(write_addr),
    .write_values(write_values), .write_en(write_en), .update_note(update_note)
  );

  midi_voice_manager #(.NUM_VOICES(NV), .ADDR_W(5), .CTRL_ADDR(16), .CHANNEL(0), .OMNI(1)) dut_omni (
    .clk(clk), .reset(reset), .new_msg(new_msg), .msg(msg),
    .voices_playing(voices_playing), .update_mixer(update_mixer),
    .ready_to_update(ready_to_update), .busy(o_busy),
    .controller_values(o_controller_values), .multiplier(o_multiplier),
    .update_all(o_update_all), .write_addr(o_write_addr),
    .write_values(o_write_values), .write_en(o_write_en), .update_note(o_update_note)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic       m_alloc [NV];
  logic [6:0] m_note  [NV];
  int         m_steal;
  logic [3:0] m_un;
  logic [13:0] m_ctrl;

  logic [4:0]  g_addr;
  logic [13:0] g_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_alloc[i] = 1'b0;
      m_note[i]  = '0;
    end
    m_steal = 0;
    m_un    = '0;
    m_ctrl  = '0;
  endtask

  function automatic logic [7:0] mult_model(input logic [3:0] p);
    int c;
    c = $countones(p);
    if (c <= 1) return 8'd255;
    return 8'(256 / c);
  endfunction

  // Predicts the write (if any), its latency and busy length for one message.
  task automatic model_msg(input logic [23:0] m, input logic [3:0] play,
                           output bit en, output int lat, output int bexp,
                           output logic [4:0] addr, output logic [13:0] val);
    logic [6:0] d1, d2;
    logic [3:0] hi;
    int sel;
    d1 = m[14:8];
    d2 = m[22:16];
    hi = m[7:4];
    en = 1'b0; lat = 0; bexp = 0; addr = '0; val = '0; sel = -1;
    if (m[3:0] == 4'd0) begin
      if (hi == 4'hB) begin
        en = 1'b1; lat = 2; bexp = 2; addr = 5'd16; val = {d1, d2};
        m_ctrl = val;
      end else if (hi == 4'h9 && d2 != 7'd0) begin
        for (int i = 0; i < NV; i++) if (sel < 0 && m_alloc[i] && m_note[i] == d1) sel = i;
        for (int i = 0; i < NV; i++) if (sel < 0 && !m_alloc[i] && !play[i]) sel = i;
        if (sel < 0) begin
          sel = m_steal;
          m_steal = (m_steal + 1) % NV;
        end
        m_alloc[sel] = 1'b1;
        m_note[sel]  = d1;
        m_un[sel]    = 1'b1;
        en = 1'b1; lat = NV + 2; bexp = NV + 2; addr = 5'(sel); val = {d2, d1};
      end else if (hi == 4'h8 || hi == 4'h9) begin
        for (int i = 0; i < NV; i++) if (sel < 0 && m_alloc[i] && m_note[i] == d1) sel = i;
        if (sel >= 0) begin
          m_alloc[sel] = 1'b0;
          m_un[sel]    = 1'b1;
          en = 1'b1; lat = NV + 2; bexp = NV + 2; addr = 5'(sel); val = {7'd0, d1};
        end else begin
          bexp = NV + 1;
        end
      end else begin
        bexp = 1;
      end
    end
  endtask

  // driver: one message; mode 1 = intruding msg in SEARCH, 2 = update_all
  // coincident with the write, 3 = reset asserted mid-search
  task automatic send(input logic [23:0] m, input logic [3:0] play, input int mode);
    bit en;
    int lat, bexp, wcnt, glat, bcnt;
    logic [4:0] ea, ga;
    logic [13:0] ev, gv;
    logic [3:0] old_un;
    logic [7:0] exp_mult;
    old_un = m_un;
    model_msg(m, play, en, lat, bexp, ea, ev);
    exp_mult = mult_model(play);
    voices_playing = play;
    msg = m;
    new_msg = 1'b1;
    tick();
    new_msg = 1'b0;
    wcnt = 0; glat = 0; bcnt = 0; ga = '0; gv = '0;
    for (int k = 1; k <= NV + 4; k++) begin
      if (mode == 1 && k == 2) begin
        new_msg = 1'b1;
        msg = 24'h7F11B0;
      end
      if (mode == 1 && k == 3) new_msg = 1'b0;
      if (mode == 2 && k == NV + 1) ready_to_update = 1'b1;
      if (mode == 2 && k == NV + 2) begin
        ready_to_update = 1'b0;
        check("sync_update_all", 32'(update_all), 32'd1);
        check("sync_write_en", 32'(write_en), 32'd1);
        check("sync_update_note", 32'(update_note), 32'(old_un));
        check("sync_multiplier", 32'(multiplier), 32'(exp_mult));
      end
      if (mode == 3 && k == 3) begin
        reset = 1'b1;
        #1;
        check("rst_mid_write_en", 32'(write_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_update_note", 32'(update_note), 32'd0);
        check("rst_mid_ctrl", 32'(controller_values), 32'd0);
        check("rst_mid_mult", 32'(multiplier), 32'd0);
        check("rst_mid_wvals", 32'(write_values), 32'd0);
        check("rst_mid_waddr", 32'(write_addr), 32'd0);
      end
      if (mode == 3 && k == 6) reset = 1'b0;
      if (write_en) begin
        wcnt++;
        if (glat == 0) begin
          glat = k; ga = write_addr; gv = write_values;
        end
      end
      if (busy) bcnt++;
      tick();
    end
    if (mode == 3) begin
      model_reset();
      en = 1'b0;
    end
    check("write_count", 32'(wcnt), 32'(en));
    if (en) begin
      check("write_latency", 32'(glat), 32'(lat));
      check("write_addr", 32'(ga), 32'(ea));
      check("write_values", 32'(gv), 32'(ev));
    end
    if (mode != 3) check("busy_cycles", 32'(bcnt), 32'(bexp));
    check("busy_idle", 32'(busy), 32'd0);
    check("controller_values", 32'(controller_values), 32'(m_ctrl));
    if (mode == 2) m_un = en ? 4'(5'd1 << ea) : 4'd0;
    check("update_note", 32'(update_note), 32'(m_un));
    g_addr = ga;
    g_val  = gv;
  endtask

  // driver: full mixer handshake with the given playing mask
  task automatic mix(input logic [3:0] play);
    logic [7:0] exp_mult;
    exp_mult = mult_model(play);
    voices_playing = play;
    update_mixer = 1'b1;
    tick();
    update_mixer = 1'b0;
    tick();
    tick();
    ready_to_update = 1'b1;
    tick();
    ready_to_update = 1'b0;
    check("mix_update_all", 32'(update_all), 32'd1);
    check("mix_update_note", 32'(update_note), 32'(m_un));
    check("mix_multiplier", 32'(multiplier), 32'(exp_mult));
    tick();
    m_un = '0;
    check("mix_update_all_end", 32'(update_all), 32'd0);
    check("mix_update_note_clr", 32'(update_note), 32'd0);
    check("mix_multiplier_hold", 32'(multiplier), 32'(exp_mult));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  int wc, owc, kind;
  logic [4:0] oaddr;
  logic [7:0] b1, b2, st;

  initial begin
    model_reset();
    tick();
    tick();
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_update_all", 32'(update_all), 32'd0);
    check("rst_update_note", 32'(update_note), 32'd0);
    check("rst_multiplier", 32'(multiplier), 32'd0);
    check("rst_ctrl", 32'(controller_values), 32'd0);
    check("rst_waddr", 32'(write_addr), 32'd0);
    check("rst_wvals", 32'(write_values), 32'd0);
    reset = 1'b0;
    tick();

    // ready without a pending request is ignored
    ready_to_update = 1'b1;
    tick();
    ready_to_update = 1'b0;
    check("stray_ready", 32'(update_all), 32'd0);

    // controller change
    send(24'h4040B0, 4'b0000, 0);
    check("tp1_addr", 32'(g_addr), 32'd16);
    check("tp1_val", 32'(g_val), 32'h2040);

    // first note-on, then a single-voice update
    send(24'h403C90, 4'b0000, 0);
    check("tp2_addr", 32'(g_addr), 32'd0);
    check("tp2_val", 32'(g_val), 32'h203C);
    mix(4'b0001);

    // fill voice 1, then voice 2 by free search
    send(24'h404190, 4'b0001, 0);
    mix(4'b0011);
    send(24'h7F4090, 4'b0011, 0);
    check("tp3_addr", 32'(g_addr), 32'd2);
    check("tp3_val", 32'(g_val), 32'h3FC0);
    mix(4'b0111);

    // note-off by velocity 0, then a note-off with no match
    send(24'h003C90, 4'b0111, 0);
    check("tp4_addr", 32'(g_addr), 32'd0);
    check("tp4_val", 32'(g_val), 32'h003C);
    send(24'h005080, 4'b0111, 0);

    // stealing and retrigger
    do_reset();
    send(24'h503090, 4'b0000, 0);
    send(24'h503190, 4'b0000, 0);
    send(24'h503290, 4'b0000, 0);
    send(24'h503390, 4'b0000, 0);
    send(24'h504890, 4'b1111, 0);
    check("steal0_addr", 32'(g_addr), 32'd0);
    send(24'h504990, 4'b1111, 0);
    check("steal1_addr", 32'(g_addr), 32'd1);
    send(24'h504890, 4'b1111, 0);
    check("retrig_addr", 32'(g_addr), 32'd0);

    // other channel: ignored normally, accepted in omni mode
    msg = 24'h403C91;
    new_msg = 1'b1;
    tick();
    new_msg = 1'b0;
    wc = 0; owc = 0; oaddr = '0;
    for (int k = 1; k <= NV + 4; k++) begin
      if (write_en) wc++;
      if (o_write_en) begin
        owc++;
        oaddr = o_write_addr;
      end
      tick();
    end
    check("chan1_ignored", 32'(wc), 32'd0);
    check("omni_accepted", 32'(owc), 32'd1);
    check("omni_addr", 32'(oaddr), 32'd2);
    check("chan1_update_note", 32'(update_note), 32'(m_un));

    // boundary cases
    send(24'h105590, 4'b1111, 1);
    update_mixer = 1'b1;
    tick();
    update_mixer = 1'b0;
    send(24'h105690, 4'b1111, 2);
    send(24'h105790, 4'b1111, 3);
    tick();

    // random traffic
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      b1 = 8'($urandom_range(60, 65));
      b2 = 8'($urandom_range(1, 127));
      st = 8'h90;
      case (kind)
        0, 1: begin
          st = 8'hB0;
          b1 = 8'($urandom_range(0, 127));
          b2 = 8'($urandom_range(0, 127));
        end
        6, 7: st = 8'h80;
        8: b2 = 8'h00;
        9: st = ($urandom_range(0, 1) == 1) ? 8'hA0 : 8'h91;
        default: st = 8'h90;
      endcase
      send({b2, b1, st}, 4'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 3) == 0) mix(4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
